// File: rtl/alu_stage_pkg.sv
// alu_stage_pkg: shared types and constants for the execute-stage ALU
// Contents: InstructionDetails struct, OPC_*/FUNC_* encodings, alu_state_e.
// Field widths are fixed here because they shape the InstructionDetails port type.
package alu_stage_pkg;
    localparam int OP_W   = 6;
    localparam int FUNC_W = 6;
    localparam int IMM_W  = 16;
    localparam int OFFS_W = 21;
    localparam int RIDX_W = 4;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [FUNC_W-1:0] func;
        logic [IMM_W-1:0]  imm;
        logic [OFFS_W-1:0] offs;
        logic [RIDX_W-1:0] rs;
        logic [RIDX_W-1:0] rt;
        logic              is_valid;
    } InstructionDetails;

    // op[0] selects the immediate form of ALU and TEST
    localparam logic [OP_W-1:0] OPC_ALU    = 6'h00;
    localparam logic [OP_W-1:0] OPC_ALU_IM = 6'h01;
    localparam logic [OP_W-1:0] OPC_TEST   = 6'h02;
    localparam logic [OP_W-1:0] OPC_TS_IM  = 6'h03;
    localparam logic [OP_W-1:0] OPC_LOAD   = 6'h04;
    localparam logic [OP_W-1:0] OPC_STORE  = 6'h06;
    localparam logic [OP_W-1:0] OPC_JUMP   = 6'h08;
    localparam logic [OP_W-1:0] OPC_BEQZ   = 6'h0A;
    localparam logic [OP_W-1:0] OPC_BNEZ   = 6'h0C;

    localparam logic [FUNC_W-1:0] FUNC_ADD  = 6'h00;
    localparam logic [FUNC_W-1:0] FUNC_SUB  = 6'h01;
    localparam logic [FUNC_W-1:0] FUNC_AND  = 6'h02;
    localparam logic [FUNC_W-1:0] FUNC_OR   = 6'h03;
    localparam logic [FUNC_W-1:0] FUNC_XOR  = 6'h04;
    localparam logic [FUNC_W-1:0] FUNC_SLL  = 6'h05;
    localparam logic [FUNC_W-1:0] FUNC_SRL  = 6'h06;
    localparam logic [FUNC_W-1:0] FUNC_SRA  = 6'h07;
    localparam logic [FUNC_W-1:0] FUNC_MUL  = 6'h08;
    localparam logic [FUNC_W-1:0] FUNC_MULU = 6'h09;
    localparam logic [FUNC_W-1:0] FUNC_DIV  = 6'h0A;
    localparam logic [FUNC_W-1:0] FUNC_DIVU = 6'h0B;

    localparam logic [FUNC_W-1:0] FUNC_SEQ  = 6'h00;
    localparam logic [FUNC_W-1:0] FUNC_SNE  = 6'h01;
    localparam logic [FUNC_W-1:0] FUNC_SLT  = 6'h02;
    localparam logic [FUNC_W-1:0] FUNC_SLTU = 6'h03;

    typedef enum logic [1:0] {IDLE, RUN, FIX} alu_state_e;
endpackage

// File: rtl/alu_stage_muldiv.sv
// alu_muldiv_iter: iterative shift-add multiply / restoring divide, one bit per cycle
// Ports: clk, rst_async (async, active-high), start (load operands),
//        a, b, is_div, is_signed -> done (1-cycle pulse), result.
// Timing: start edge loads, XLEN edges iterate, one edge applies the sign, done follows.
// Present only when ALU_MULDIV_EN is defined.
`ifdef ALU_MULDIV_EN
module alu_muldiv_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_async,
    input  logic            start,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            is_div,
    input  logic            is_signed,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CNT_W = $clog2(XLEN);

    logic [XLEN-1:0]  r_acc, r_q, r_m, r_res;
    logic [CNT_W-1:0] r_cnt;
    logic             r_div, r_neg, r_dz, r_run, r_fix, r_done;
    logic [XLEN-1:0]  w_abs_a, w_abs_b, w_raw;
    logic [XLEN:0]    w_sh, w_sub;

    assign w_abs_a = (is_signed && a[XLEN-1]) ? -a : a;
    assign w_abs_b = (is_signed && b[XLEN-1]) ? -b : b;
    // restoring step: a clear borrow bit means the divisor fits
    assign w_sh    = {r_acc, r_q[XLEN-1]};
    assign w_sub   = w_sh - {1'b0, r_m};
    assign w_raw   = r_div ? r_q : r_acc;

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            r_acc  <= '0;
            r_q    <= '0;
            r_m    <= '0;
            r_res  <= '0;
            r_cnt  <= '0;
            r_div  <= 1'b0;
            r_neg  <= 1'b0;
            r_dz   <= 1'b0;
            r_run  <= 1'b0;
            r_fix  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_acc <= '0;
                r_q   <= w_abs_a;
                r_m   <= w_abs_b;
                r_div <= is_div;
                r_neg <= is_signed & (a[XLEN-1] ^ b[XLEN-1]);
                r_dz  <= is_div & (b == '0);
                r_cnt <= '0;
                r_run <= 1'b1;
                r_fix <= 1'b0;
            end else if (r_run) begin
                r_acc <= r_div ? (w_sub[XLEN] ? w_sh[XLEN-1:0] : w_sub[XLEN-1:0])
                               : r_acc + (r_q[0] ? r_m : '0);
                r_q   <= r_div ? {r_q[XLEN-2:0], !w_sub[XLEN]} : r_q >> 1;
                r_m   <= r_div ? r_m : r_m << 1;
                r_cnt <= r_cnt + 1'b1;
                if (r_cnt == CNT_W'(XLEN - 1)) begin
                    r_run <= 1'b0;
                    r_fix <= 1'b1;
                end
            end else if (r_fix) begin
                // MIN/-1 needs no special case: |MIN| negated twice stays MIN
                r_res  <= r_dz ? '1 : (r_neg ? -w_raw : w_raw);
                r_done <= 1'b1;
                r_fix  <= 1'b0;
            end
        end
    end

    assign done   = r_done;
    assign result = r_res;
endmodule
`endif

// File: rtl/alu_stage.sv
// alu_stage: execute-stage ALU with valid/ready handshakes on input and output
// Ports: clk, rst_async (async, active-high); in_valid/in_ready/details input handshake;
//        read_a_index/read_b_index register-file indices (combinational from details);
//        read_a/read_b operands; out_valid/out_ready/out/out_details output handshake;
//        busy while a multi-cycle op runs.
// Config: ALU_MULDIV_EN enables MUL/MULU/DIV/DIVU via IDLE->RUN->FIX; otherwise they are illegal.
module alu_stage
    import alu_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst_async,
    input  logic              in_valid,
    output logic              in_ready,
    input  InstructionDetails details,
    output logic [RIDX_W-1:0] read_a_index,
    output logic [RIDX_W-1:0] read_b_index,
    input  logic [XLEN-1:0]   read_a,
    input  logic [XLEN-1:0]   read_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out,
    output InstructionDetails out_details,
    output logic              busy
);
    localparam int SH_W = $clog2(XLEN);

    logic              r_out_valid;
    logic [XLEN-1:0]   r_out;
    InstructionDetails r_det;
    InstructionDetails w_det;
    logic [XLEN-1:0]   w_opb, w_res, w_md_res;
    logic [SH_W-1:0]   w_shamt;
    logic              w_legal, w_md, w_accept, w_start, w_md_done;

    assign read_a_index = details.rs;
    assign read_b_index = details.rt;
    assign w_opb        = details.op[0] ? XLEN'(details.imm) : read_b;
    assign w_shamt      = w_opb[SH_W-1:0];
    assign in_ready     = !busy & (!r_out_valid | out_ready);
    assign w_accept     = in_valid & in_ready;
    assign w_start      = w_accept & w_md & details.is_valid;

    always_comb begin
        w_res   = '0;
        w_legal = 1'b1;
        w_md    = 1'b0;
        case (details.op)
            OPC_ALU, OPC_ALU_IM:
                case (details.func)
                    FUNC_ADD: w_res = read_a + w_opb;
                    FUNC_SUB: w_res = read_a - w_opb;
                    FUNC_AND: w_res = read_a & w_opb;
                    FUNC_OR:  w_res = read_a | w_opb;
                    FUNC_XOR: w_res = read_a ^ w_opb;
                    FUNC_SLL: w_res = read_a << w_shamt;
                    FUNC_SRL: w_res = read_a >> w_shamt;
                    FUNC_SRA: w_res = $signed(read_a) >>> w_shamt;
`ifdef ALU_MULDIV_EN
                    FUNC_MUL, FUNC_MULU, FUNC_DIV, FUNC_DIVU: w_md = 1'b1;
`endif
                    default:  w_legal = 1'b0;
                endcase
            OPC_TEST, OPC_TS_IM:
                case (details.func)
                    FUNC_SEQ:  w_res = XLEN'(read_a == w_opb);
                    FUNC_SNE:  w_res = XLEN'(read_a != w_opb);
                    FUNC_SLT:  w_res = XLEN'($signed(read_a) < $signed(w_opb));
                    FUNC_SLTU: w_res = XLEN'(read_a < w_opb);
                    default:   w_legal = 1'b0;
                endcase
            OPC_LOAD, OPC_STORE, OPC_JUMP: w_res = read_a + XLEN'(details.offs);
            OPC_BEQZ: w_res = XLEN'(read_a == '0);
            OPC_BNEZ: w_res = XLEN'(read_a != '0);
            default:  w_legal = 1'b0;
        endcase
        if (!(w_legal && details.is_valid)) w_res = '0;
        w_det          = details;
        w_det.is_valid = details.is_valid & w_legal;
    end

`ifdef ALU_MULDIV_EN
    alu_state_e       r_state, w_state_nxt;
    logic [SH_W-1:0]  r_cnt;
    logic             w_done;

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= (r_state == RUN) ? r_cnt + 1'b1 : '0;
        end
    end

    // FIX lasts until the sub-module has applied the sign and pulses done
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = w_start ? RUN : IDLE;
            RUN:     w_state_nxt = (r_cnt == SH_W'(XLEN - 1)) ? FIX : RUN;
            FIX:     w_state_nxt = w_done ? IDLE : FIX;
            default: w_state_nxt = IDLE;
        endcase
    end

    alu_muldiv_iter #(.XLEN(XLEN)) u_muldiv (
        .clk       (clk),
        .rst_async (rst_async),
        .start     (w_start),
        .a         (read_a),
        .b         (w_opb),
        .is_div    (details.func == FUNC_DIV || details.func == FUNC_DIVU),
        .is_signed (details.func == FUNC_MUL || details.func == FUNC_DIV),
        .done      (w_done),
        .result    (w_md_res)
    );

    assign busy      = r_state != IDLE;
    assign w_md_done = (r_state == FIX) & w_done;
`else
    assign busy      = 1'b0;
    assign w_md_done = 1'b0;
    assign w_md_res  = '0;
`endif

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_det       <= '0;
        end else if (w_accept) begin
            r_out_valid <= !w_start;
            r_out       <= w_res;
            r_det       <= w_det;
        end else if (w_md_done) begin
            r_out_valid <= 1'b1;
            r_out       <= w_md_res;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid   = r_out_valid;
    assign out         = r_out;
    assign out_details = r_det;
endmodule

// File: tb/tb_alu_stage.sv
// tb_alu_stage: directed self-checking bench for alu_stage (XLEN=32)
module tb_alu_stage;
    import alu_stage_pkg::*;

    logic              clk = 1'b0;
    logic              rst_async, in_valid, out_ready;
    logic              in_ready, out_valid, busy;
    InstructionDetails details, out_details;
    logic [3:0]        ra_idx, rb_idx;
    logic [31:0]       read_a, read_b, dout;
    int                n_chk = 0, n_pass = 0;

    typedef struct packed {
        logic [5:0]  op;
        logic [5:0]  func;
        logic [15:0] imm;
        logic [20:0] offs;
        logic [31:0] a, b, exp;
    } vec_t;

    typedef struct packed {
        logic [5:0]  func;
        logic [31:0] a, b, exp;
    } md_t;

    typedef struct packed {
        logic [5:0] op;
        logic [5:0] func;
        logic       v;
    } il_t;

    alu_stage #(.XLEN(32)) dut (
        .clk          (clk),
        .rst_async    (rst_async),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .details      (details),
        .read_a_index (ra_idx),
        .read_b_index (rb_idx),
        .read_a       (read_a),
        .read_b       (read_b),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out          (dout),
        .out_details  (out_details),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic drive(input logic [5:0] op, input logic [5:0] func, input logic [15:0] imm,
                         input logic [20:0] offs, input logic [31:0] a, input logic [31:0] b,
                         input logic v);
        details          = '0;
        details.op       = op;
        details.func     = func;
        details.imm      = imm;
        details.offs     = offs;
        details.rs       = 4'd1;
        details.rt       = 4'd2;
        details.is_valid = v;
        read_a           = a;
        read_b           = b;
        in_valid         = 1'b1;
    endtask

    task automatic test_reset;
        rst_async = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        details   = '0;
        read_a    = '0;
        read_b    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_chk++;
        if ({out_valid, busy, dout, out_details} !== '0)
            $display("FAIL reset_state got v=%b b=%b out=%h det=%h want all zero", out_valid, busy, dout, out_details);
        else n_pass++;
        rst_async = 1'b0;
        @(posedge clk); #1;
        n_chk++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready);
        else n_pass++;
    endtask

    task automatic test_add;
        @(negedge clk);
        drive(OPC_ALU, FUNC_ADD, 16'h0, 21'h0, 32'd5, 32'd7, 1'b1);
        details.rs = 4'd5;
        details.rt = 4'd7;
        #1;
        n_chk++;
        if ({ra_idx, rb_idx} !== 8'h57) $display("FAIL read_index got %h%h want 57", ra_idx, rb_idx);
        else n_pass++;
        @(posedge clk); #1;
        n_chk++;
        if ({out_valid, out_details.is_valid, out_details.rs, dout} !== {2'b11, 4'd5, 32'd12})
            $display("FAIL add got v=%b iv=%b rs=%h out=%h want 1 1 5 0000000c",
                     out_valid, out_details.is_valid, out_details.rs, dout);
        else n_pass++;
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        n_chk++;
        if (out_valid !== 1'b0) $display("FAIL add_drain got out_valid=%b want 0", out_valid);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        vec_t v [19];
        v = '{
            '{OPC_ALU,    FUNC_ADD,  16'h0,    21'h0,      32'hFFFFFFFF, 32'h2,        32'h00000001},
            '{OPC_ALU,    FUNC_SUB,  16'h0,    21'h0,      32'h3,        32'h5,        32'hFFFFFFFE},
            '{OPC_ALU,    FUNC_AND,  16'h0,    21'h0,      32'hF0F0,     32'hFF00,     32'h0000F000},
            '{OPC_ALU,    FUNC_OR,   16'h0,    21'h0,      32'hF0F0,     32'hFF00,     32'h0000FFF0},
            '{OPC_ALU,    FUNC_XOR,  16'h0,    21'h0,      32'hFF,       32'h0F,       32'h000000F0},
            '{OPC_ALU,    FUNC_SLL,  16'h0,    21'h0,      32'h1,        32'h21,       32'h00000002},
            '{OPC_ALU,    FUNC_SRL,  16'h0,    21'h0,      32'h80000000, 32'd31,       32'h00000001},
            '{OPC_ALU_IM, FUNC_SRA,  16'h4,    21'h0,      32'h80000000, 32'h0,        32'hF8000000},
            '{OPC_TEST,   FUNC_SLT,  16'h0,    21'h0,      32'hFFFFFFFF, 32'h1,        32'h00000001},
            '{OPC_TEST,   FUNC_SLTU, 16'h0,    21'h0,      32'hFFFFFFFF, 32'h1,        32'h00000000},
            '{OPC_TS_IM,  FUNC_SEQ,  16'h1234, 21'h0,      32'h1234,     32'hDEADBEEF, 32'h00000001},
            '{OPC_TEST,   FUNC_SNE,  16'h0,    21'h0,      32'h5,        32'h5,        32'h00000000},
            '{OPC_ALU_IM, FUNC_ADD,  16'hFFFF, 21'h0,      32'h1,        32'hDEADBEEF, 32'h00010000},
            '{OPC_LOAD,   FUNC_ADD,  16'h0,    21'h1FFFFF, 32'h100,      32'h0,        32'h002000FF},
            '{OPC_BEQZ,   FUNC_ADD,  16'h0,    21'h0,      32'h0,        32'h0,        32'h00000001},
            '{OPC_BNEZ,   FUNC_ADD,  16'h0,    21'h0,      32'h0,        32'h0,        32'h00000000},
            '{OPC_BNEZ,   FUNC_ADD,  16'h0,    21'h0,      32'h7,        32'h0,        32'h00000001},
            '{OPC_ALU,    FUNC_SRA,  16'h0,    21'h0,      32'h40000000, 32'h2,        32'h10000000},
            '{OPC_JUMP,   FUNC_ADD,  16'h0,    21'h1,      32'hFFFFFFFF, 32'h0,        32'h00000000}
        };
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            drive(v[i].op, v[i].func, v[i].imm, v[i].offs, v[i].a, v[i].b, 1'b1);
            @(posedge clk); #1;
            n_chk++;
            if ({out_valid, out_details.is_valid, dout} !== {2'b11, v[i].exp})
                $display("FAIL op_vec%0d got v=%b iv=%b out=%h want 1 1 %h",
                         i, out_valid, out_details.is_valid, dout, v[i].exp);
            else n_pass++;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_backpressure;
        @(negedge clk);
        drive(OPC_ALU, FUNC_ADD, 16'h0, 21'h0, 32'd10, 32'd20, 1'b1);
        out_ready = 1'b0;
        @(posedge clk); #1;
        n_chk++;
        if ({out_valid, dout} !== {1'b1, 32'd30}) $display("FAIL bp_first got v=%b out=%h want 1 1e", out_valid, dout);
        else n_pass++;
        @(negedge clk);
        drive(OPC_ALU, FUNC_SUB, 16'h0, 21'h0, 32'd9, 32'd4, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_chk++;
            if ({out_valid, in_ready, dout} !== {2'b10, 32'd30})
                $display("FAIL bp_hold%0d got v=%b rdy=%b out=%h want 1 0 1e", i, out_valid, in_ready, dout);
            else n_pass++;
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        n_chk++;
        if (in_ready !== 1'b1) $display("FAIL bp_release_ready got %b want 1", in_ready);
        else n_pass++;
        @(posedge clk); #1;
        n_chk++;
        if ({out_valid, dout} !== {1'b1, 32'd5}) $display("FAIL bp_next got v=%b out=%h want 1 5", out_valid, dout);
        else n_pass++;
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        n_chk++;
        if (out_valid !== 1'b0) $display("FAIL bp_drain got %b want 0", out_valid);
        else n_pass++;
    endtask

    task automatic test_illegal;
        il_t il [6];
        il = '{
            '{OPC_ALU,  6'h3F,     1'b1},
            '{OPC_TEST, 6'h3F,     1'b1},
            '{6'h3E,    FUNC_ADD,  1'b1},
            '{OPC_ALU,  FUNC_ADD,  1'b0},
            '{OPC_ALU,  FUNC_MUL,  1'b0},
            '{OPC_ALU,  6'h20,     1'b1}
        };
`ifndef ALU_MULDIV_EN
        il[5] = '{OPC_ALU, FUNC_MUL, 1'b1};
`endif
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive(il[i].op, il[i].func, 16'h0, 21'h0, 32'd1, 32'd2, il[i].v);
            @(posedge clk); #1;
            n_chk++;
            if ({out_valid, out_details.is_valid, busy, out_details.func, dout} !== {3'b100, il[i].func, 32'd0})
                $display("FAIL illegal%0d got v=%b iv=%b busy=%b func=%h out=%h want 1 0 0 %h 0",
                         i, out_valid, out_details.is_valid, busy, out_details.func, dout, il[i].func);
            else n_pass++;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

`ifdef ALU_MULDIV_EN
    task automatic test_muldiv;
        md_t m [9];
        int  n;
        bit  bad;
        m = '{
            '{FUNC_MUL,  32'h0000FFFF, 32'h00010001, 32'hFFFFFFFF},
            '{FUNC_MUL,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFF1},
            '{FUNC_MULU, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFF1},
            '{FUNC_MUL,  32'h00000007, 32'h00000006, 32'h0000002A},
            '{FUNC_DIV,  32'h00000007, 32'h00000000, 32'hFFFFFFFF},
            '{FUNC_DIV,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD},
            '{FUNC_DIVU, 32'h00000064, 32'h00000007, 32'h0000000E},
            '{FUNC_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000},
            '{FUNC_DIVU, 32'hFFFFFFFF, 32'h00000010, 32'h0FFFFFFF}
        };
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            drive(OPC_ALU, m[i].func, 16'h0, 21'h0, m[i].a, m[i].b, 1'b1);
            @(posedge clk); #1;
            bad = (busy !== 1'b1) || (out_valid !== 1'b0);
            @(negedge clk);
            in_valid = 1'b0;
            n = 0;
            while (n < 100) begin
                @(posedge clk); #1;
                n++;
                if (out_valid === 1'b1) break;
                if (busy !== 1'b1 || in_ready !== 1'b0) bad = 1'b1;
            end
            n_chk++;
            if (n !== 34 || bad) $display("FAIL md%0d_timing got edges=%0d busy_gap=%b want 34 0", i, n, bad);
            else n_pass++;
            n_chk++;
            if ({out_valid, busy, out_details.is_valid, dout} !== {3'b101, m[i].exp})
                $display("FAIL md%0d_result got v=%b busy=%b iv=%b out=%h want 1 0 1 %h",
                         i, out_valid, busy, out_details.is_valid, dout, m[i].exp);
            else n_pass++;
        end
    endtask
`endif

    task automatic test_reset_mid_op;
        @(negedge clk);
`ifdef ALU_MULDIV_EN
        drive(OPC_ALU, FUNC_MUL, 16'h0, 21'h0, 32'd3, 32'd4, 1'b1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
`else
        drive(OPC_ALU, FUNC_ADD, 16'h0, 21'h0, 32'd3, 32'd4, 1'b1);
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
`endif
        #2;
        rst_async = 1'b1;
        #1;
        n_chk++;
        if ({out_valid, busy, dout} !== '0) $display("FAIL rst_mid got v=%b busy=%b out=%h want 0 0 0", out_valid, busy, dout);
        else n_pass++;
        @(negedge clk);
        rst_async = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_chk++;
        if ({in_ready, out_valid} !== 2'b10) $display("FAIL rst_release got rdy=%b v=%b want 1 0", in_ready, out_valid);
        else n_pass++;
        @(negedge clk);
        drive(OPC_ALU, FUNC_ADD, 16'h0, 21'h0, 32'd2, 32'd3, 1'b1);
        @(posedge clk); #1;
        n_chk++;
        if ({out_valid, out_details.is_valid, dout} !== {2'b11, 32'd5})
            $display("FAIL rst_next_add got v=%b iv=%b out=%h want 1 1 5", out_valid, out_details.is_valid, dout);
        else n_pass++;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        n_chk++;
        if ({out_valid, busy} !== 2'b00) $display("FAIL rst_dropped got v=%b busy=%b want 0 0", out_valid, busy);
        else n_pass++;
    endtask

    initial begin
        test_reset;
        test_add;
        test_back_to_back;
        test_backpressure;
        test_illegal;
`ifdef ALU_MULDIV_EN
        test_muldiv;
`endif
        test_reset_mid_op;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
